// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//
// Sequences the MEM stage of the pipelined CPU. A load or store sitting in
// the EX/MEM register is launched to a variable-latency data memory over a
// registered req/ack handshake. While the transaction is outstanding the
// upstream pipeline registers are frozen through `stall`. Load data is
// returned to MEM/WB with a one-cycle `load_valid` pulse. A transaction that
// receives no ack within TIMEOUT cycles is abandoned and flagged in the
// sticky `err` bit, which also records an illegal read+write request.
// Every stalled cycle is counted in a saturating counter.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous reset, active low
//   mem_read    EX/MEM control: instruction is a load
//   mem_write   EX/MEM control: instruction is a store
//   mem_addr    EX/MEM ALU result, used as the memory address
//   mem_wdata   EX/MEM store data
//   err_clr     clears the sticky err flag (a set in the same cycle wins)
//   dmem_req    registered memory request
//   dmem_we     1 = write, 0 = read; meaningful while dmem_req is high
//   dmem_addr   latched address
//   dmem_wdata  latched store data
//   dmem_ack    one-cycle memory completion pulse, honoured only in REQ
//   dmem_rdata  read data, valid together with dmem_ack
//   stall       freezes PC, IF/ID, ID/EX and EX/MEM
//   load_valid  one-cycle pulse, load_data valid for MEM/WB
//   load_data   captured read data
//   err         sticky timeout / illegal-operation flag
//   stall_cnt   saturating count of cycles with stall high
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int WORD_LEN = 8,
  parameter int TIMEOUT  = 15,   // legal range 1..255
  parameter int CNT_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [WORD_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_wdata,
  input  logic                err_clr,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic                dmem_ack,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  output logic                stall,
  output logic                load_valid,
  output logic [WORD_LEN-1:0] load_data,
  output logic                err,
  output logic [CNT_LEN-1:0]  stall_cnt
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The timer only has to reach TIMEOUT-1, and TIMEOUT never exceeds 255.
  localparam int         TIMER_W    = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]          state_q,      state_d;
  logic                dmem_req_q,   dmem_req_d;
  logic                dmem_we_q,    dmem_we_d;
  logic [WORD_LEN-1:0] dmem_addr_q,  dmem_addr_d;
  logic [WORD_LEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic                load_valid_q, load_valid_d;
  logic [WORD_LEN-1:0] load_data_q,  load_data_d;
  logic                err_q,        err_d;
  logic [CNT_LEN-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [TIMER_W-1:0]  timer_q,      timer_d;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic access;
  logic illegal_op;
  logic timed_out;
  logic err_set;

  assign access     = mem_read | mem_write;
  // Both controls high is not a real instruction; it is issued as a store.
  assign illegal_op = (state_q == ST_IDLE) & mem_read & mem_write;
  // An ack on the last allowed cycle still completes the access normally.
  assign timed_out  = (state_q == ST_REQ) & ~dmem_ack & (timer_q == TIMER_LAST);
  assign err_set    = illegal_op | timed_out;

  // Stall is combinational so the very cycle that presents an access already
  // holds the pipeline; DONE releases it for exactly one advance, which moves
  // the finished instruction out of EX/MEM and avoids issuing it twice.
  assign stall = ((state_q == ST_IDLE) & access) | (state_q == ST_REQ);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    timer_d      = timer_q;

    unique case (state_q)
      ST_IDLE: begin
        // Non-memory instructions pass through; dmem outputs are held.
        if (access) begin
          dmem_addr_d  = mem_addr;
          dmem_wdata_d = mem_wdata;
          dmem_we_d    = mem_write;
          dmem_req_d   = 1'b1;
          timer_d      = '0;
          state_d      = ST_REQ;
        end
      end

      ST_REQ: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (!dmem_we_q) begin
            load_data_d  = dmem_rdata;
            load_valid_d = 1'b1;
          end
          state_d = ST_DONE;
        end else if (timer_q == TIMER_LAST) begin
          // Abandon the access; the memory side must tolerate this.
          dmem_req_d  = 1'b0;
          load_data_d = '0;
          state_d     = ST_DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // Sticky error: a set in the same cycle overrides a clear request.
  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Saturating stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_LEN'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: the data registers (address, store data, load data) are reset too,
  // because their reset value is architecturally visible on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      timer_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      timer_q      <= timer_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign err        = err_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
